sig_period_meter: RTL and testbench

Synthesisable, parametrised clock/signal characterisation block: measures high time, low time and period of an asynchronous input `sig_in` in `clk` cycles, continuously, one result per input period. It also tracks the minimum and maximum period and counts measurements. It sits beside clock-generation and test logic as an on-chip monitor, and replaces simulation-only `$time` measurement with cycle-accurate hardware results readable by a host or checker.

---
 rtl/sig_meter_pkg.sv | 20 ++
 rtl/sig_period_meter_if.sv | 32 +++
 rtl/sync_edge_det.sv | 33 +++
 rtl/sig_period_meter.sv | 141 ++++++++++++++
 tb/tb_sig_period_meter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sig_meter_pkg.sv
// Shared types and constants for the signal period meter: FSM state encoding,
// default widths and the phase-counter saturation value.
package sig_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_e;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_MCNT_W      = 16;

    // Largest value a w-bit phase counter can hold before it saturates.
    function automatic logic [31:0] sat_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/sig_period_meter_if.sv
// Control inputs and published results of the period meter, bundled for
// connection between the meter (slave) and whoever drives/consumes it (master).
interface sig_period_meter_if
    import sig_meter_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int MCNT_W = DEF_MCNT_W
);
    logic              sig_in;
    logic              enable;
    logic              clr_stats;
    logic              meas_valid;
    logic [CNT_W-1:0]  high_cnt;
    logic [CNT_W-1:0]  low_cnt;
    logic [CNT_W:0]    period_cnt;
    logic              overflow;
    logic [CNT_W:0]    period_min;
    logic [CNT_W:0]    period_max;
    logic [MCNT_W-1:0] meas_count;

    modport master (
        output sig_in, enable, clr_stats,
        input  meas_valid, high_cnt, low_cnt, period_cnt, overflow,
               period_min, period_max, meas_count
    );

    modport slave (
        input  sig_in, enable, clr_stats,
        output meas_valid, high_cnt, low_cnt, period_cnt, overflow,
               period_min, period_max, meas_count
    );
endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous input plus one delay flop,
// giving the synchronised level and single-cycle rise/fall strobes.
module sync_edge_det
    import sig_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_dly_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, like real hardware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            level_dly_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], d};
            level_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_dly_q;
    assign fall  = ~level & level_dly_q;
endmodule

// File: rtl/sig_period_meter.sv
// Continuously measures high, low and total period of an asynchronous signal
// in clk cycles, publishing one result per input period with min/max/count.
module sig_period_meter
    import sig_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int MCNT_W      = DEF_MCNT_W
) (
    input  logic              clk,
    input  logic              rst,
    sig_period_meter_if.slave bus
);
    localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_max(CNT_W));
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic level, rise, fall;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (bus.sig_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  high_q, high_d, low_q, low_d;
    logic              ovf_q, ovf_d;
    logic              publish;
    logic [CNT_W:0]    period;

    logic              valid_q;
    logic [CNT_W-1:0]  pub_high_q, pub_low_q;
    logic [CNT_W:0]    pub_period_q;
    logic              pub_ovf_q;
    logic [CNT_W:0]    min_q, min_d, max_q, max_d;
    logic [MCNT_W-1:0] count_q, count_d;

    assign period = {1'b0, high_q} + {1'b0, low_q};

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        high_d  = high_q;
        low_d   = low_q;
        ovf_d   = ovf_q;
        publish = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (rise) begin
                    state_d = HIGH;
                    high_d  = ONE;
                    ovf_d   = 1'b0;
                end
                HIGH: if (fall) begin
                    state_d = LOW;
                    low_d   = ONE;
                end else if (level) begin
                    if (high_q == SAT) ovf_d = 1'b1;
                    else               high_d = high_q + 1'b1;
                end
                LOW: if (rise) begin
                    publish = 1'b1;
                    state_d = HIGH;
                    high_d  = ONE;
                    ovf_d   = 1'b0;
                end else if (!level) begin
                    if (low_q == SAT) ovf_d = 1'b1;
                    else              low_d = low_q + 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A clear coinciding with a publish is applied first, so the stats restart
    // from the measurement being published.
    always_comb begin
        min_d   = min_q;
        max_d   = max_q;
        count_d = count_q;
        if (bus.clr_stats) begin
            min_d   = '1;
            max_d   = '0;
            count_d = '0;
        end
        if (publish) begin
            count_d = count_d + 1'b1;
            if (!ovf_q) begin
                if (period < min_d) min_d = period;
                if (period > max_d) max_d = period;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            high_q       <= '0;
            low_q        <= '0;
            ovf_q        <= 1'b0;
            valid_q      <= 1'b0;
            pub_high_q   <= '0;
            pub_low_q    <= '0;
            pub_period_q <= '0;
            pub_ovf_q    <= 1'b0;
            min_q        <= '1;
            max_q        <= '0;
            count_q      <= '0;
        end else begin
            state_q <= state_d;
            high_q  <= high_d;
            low_q   <= low_d;
            ovf_q   <= ovf_d;
            valid_q <= publish;
            if (publish) begin
                pub_high_q   <= high_q;
                pub_low_q    <= low_q;
                pub_period_q <= period;
                pub_ovf_q    <= ovf_q;
            end
            min_q   <= min_d;
            max_q   <= max_d;
            count_q <= count_d;
        end
    end

    assign bus.meas_valid = valid_q;
    assign bus.high_cnt   = pub_high_q;
    assign bus.low_cnt    = pub_low_q;
    assign bus.period_cnt = pub_period_q;
    assign bus.overflow   = pub_ovf_q;
    assign bus.period_min = min_q;
    assign bus.period_max = max_q;
    assign bus.meas_count = count_q;
endmodule

// File: tb/tb_sig_period_meter.sv
// Scoreboard bench: two meters (16-bit and 4-bit phase counters) see the same
// randomized periods; a period-level model predicts each published result.
module tb_sig_period_meter;
    import sig_meter_pkg::*;

    localparam int W16 = 16;
    localparam int W4  = 4;
    localparam int MW  = 16;
    localparam int SS  = 2;
    localparam int LAT = SS + 1;

    typedef struct {
        longint hi, lo, per, ovf, mn, mx, cnt, due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig, en, clr;
    int unsigned cyc = 0;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t   q16[$], q4[$];
    exp_t   e16, e4, last16;
    longint m_min[2], m_max[2], m_cnt[2];
    bit     armed;
    int unsigned pend_h, pend_l;
    int unsigned clr_cyc;

    sig_period_meter_if #(.CNT_W(W16), .MCNT_W(MW)) bus16 ();
    sig_period_meter_if #(.CNT_W(W4),  .MCNT_W(MW)) bus4 ();

    assign bus16.sig_in    = sig;
    assign bus16.enable    = en;
    assign bus16.clr_stats = clr;
    assign bus4.sig_in     = sig;
    assign bus4.enable     = en;
    assign bus4.clr_stats  = clr;

    sig_period_meter #(.CNT_W(W16), .SYNC_STAGES(SS), .MCNT_W(MW)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    sig_period_meter #(.CNT_W(W4), .SYNC_STAGES(SS), .MCNT_W(MW)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic init_model();
        m_min[0] = (longint'(1) << (W16 + 1)) - 1;
        m_min[1] = (longint'(1) << (W4 + 1)) - 1;
        m_max[0] = 0;
        m_max[1] = 0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        q16.delete();
        q4.delete();
        armed   = 1'b0;
        clr_cyc = 32'hFFFF_FFFF;
    endtask

    // One completed input period becomes one published result, with phase
    // lengths clipped at the counter ceiling.
    task automatic model_push(int k, int unsigned h, int unsigned l, bit do_clr);
        longint w   = (k == 0) ? W16 : W4;
        longint sat = (longint'(1) << w) - 1;
        exp_t   e;
        e.hi  = (h > sat) ? sat : h;
        e.lo  = (l > sat) ? sat : l;
        e.per = e.hi + e.lo;
        e.ovf = (h > sat || l > sat) ? 1 : 0;
        if (do_clr) begin
            m_min[k] = (longint'(1) << (w + 1)) - 1;
            m_max[k] = 0;
            m_cnt[k] = 0;
        end
        m_cnt[k] = (m_cnt[k] + 1) % (longint'(1) << MW);
        if (e.ovf == 0) begin
            if (e.per < m_min[k]) m_min[k] = e.per;
            if (e.per > m_max[k]) m_max[k] = e.per;
        end
        e.mn  = m_min[k];
        e.mx  = m_max[k];
        e.cnt = m_cnt[k];
        e.due = cyc + LAT;
        if (k == 0) q16.push_back(e);
        else        q4.push_back(e);
    endtask

    task automatic tick(logic v);
        @(posedge clk);
        #1;
        sig = v;
        clr = (cyc == clr_cyc);
    endtask

    // The rising edge that opens this period closes the previous one.
    task automatic drive_period(int unsigned h, int unsigned l, bit do_clr);
        @(posedge clk);
        #1;
        if (armed) begin
            model_push(0, pend_h, pend_l, do_clr);
            model_push(1, pend_h, pend_l, do_clr);
            if (do_clr) clr_cyc = cyc + 2;
        end
        sig    = 1'b1;
        clr    = (cyc == clr_cyc);
        armed  = en;
        pend_h = h;
        pend_l = l;
        repeat (h - 1) tick(1'b1);
        repeat (l) tick(1'b0);
    endtask

    task automatic drive_broken(int unsigned h, int unsigned l1, int unsigned off, int unsigned l2);
        drive_period(h, l1, 1'b0);
        armed = 1'b0;
        for (int i = 0; i < int'(off); i++) begin
            tick(1'b0);
            en = 1'b0;
        end
        check("hold_high",   bus16.high_cnt,   last16.hi);
        check("hold_period", bus16.period_cnt, last16.per);
        check("hold_count",  bus16.meas_count, last16.cnt);
        tick(1'b0);
        en = 1'b1;
        repeat (l2 - 1) tick(1'b0);
    endtask

    task automatic check_reset(string tag);
        check({tag, "_valid"},  bus16.meas_valid, 0);
        check({tag, "_high"},   bus16.high_cnt,   0);
        check({tag, "_low"},    bus16.low_cnt,    0);
        check({tag, "_period"}, bus16.period_cnt, 0);
        check({tag, "_ovf"},    bus16.overflow,   0);
        check({tag, "_min"},    bus16.period_min, (longint'(1) << (W16 + 1)) - 1);
        check({tag, "_max"},    bus16.period_max, 0);
        check({tag, "_count"},  bus16.meas_count, 0);
        check({tag, "_min4"},   bus4.period_min,  (longint'(1) << (W4 + 1)) - 1);
        check({tag, "_count4"}, bus4.meas_count,  0);
    endtask

    task automatic compare(string tag, exp_t e, longint hi, longint lo, longint per,
                           longint ovf, longint mn, longint mx, longint cnt);
        check({tag, "_high"},    hi,  e.hi);
        check({tag, "_low"},     lo,  e.lo);
        check({tag, "_period"},  per, e.per);
        check({tag, "_ovf"},     ovf, e.ovf);
        check({tag, "_min"},     mn,  e.mn);
        check({tag, "_max"},     mx,  e.mx);
        check({tag, "_count"},   cnt, e.cnt);
        check({tag, "_latency"}, cyc, e.due);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus16.meas_valid) begin
                if (q16.size() == 0) begin
                    check("unexpected_valid16", bus16.meas_valid, 0);
                end else begin
                    e16    = q16.pop_front();
                    last16 = e16;
                    compare("m16", e16, bus16.high_cnt, bus16.low_cnt, bus16.period_cnt,
                            bus16.overflow, bus16.period_min, bus16.period_max, bus16.meas_count);
                end
            end
            if (q16.size() > 0 && cyc > q16[0].due) begin
                check("missed_valid16", cyc, q16[0].due);
                void'(q16.pop_front());
            end
            if (bus4.meas_valid) begin
                if (q4.size() == 0) begin
                    check("unexpected_valid4", bus4.meas_valid, 0);
                end else begin
                    e4 = q4.pop_front();
                    compare("m4", e4, bus4.high_cnt, bus4.low_cnt, bus4.period_cnt,
                            bus4.overflow, bus4.period_min, bus4.period_max, bus4.meas_count);
                end
            end
            if (q4.size() > 0 && cyc > q4[0].due) begin
                check("missed_valid4", cyc, q4[0].due);
                void'(q4.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b0;
        sig = 1'b0;
        en  = 1'b0;
        clr = 1'b0;
        init_model();
        #1 rst = 1'b1;
        #5 check_reset("por");
        tick(1'b0);
        tick(1'b0);
        rst = 1'b0;
        tick(1'b0);
        en = 1'b1;
        repeat (3) tick(1'b0);

        repeat (4) drive_period(5, 3, 1'b0);

        // Periods 8, 12, 6 after a clear that lands on the first publish.
        drive_period(4, 4, 1'b0);
        drive_period(6, 6, 1'b1);
        drive_period(3, 3, 1'b0);
        drive_period(5, 5, 1'b0);
        drive_period(6, 2, 1'b1);

        // Saturates only the 4-bit meter.
        drive_period(20, 2, 1'b0);

        repeat (10) drive_period($urandom_range(12, 1), $urandom_range(12, 1), 1'b0);

        drive_broken(6, 3, 4, 5);
        drive_period(4, 4, 1'b0);
        drive_period(5, 3, 1'b0);

        drive_period(10, 0, 1'b0);
        #3 rst = 1'b1;
        #1 check_reset("mid");
        init_model();
        sig = 1'b0;
        tick(1'b0);
        tick(1'b0);
        rst = 1'b0;
        repeat (3) tick(1'b0);
        drive_period(7, 2, 1'b0);
        drive_period(3, 4, 1'b0);
        drive_period(2, 2, 1'b0);
        drive_period(1, 1, 1'b0);
        repeat (8) tick(1'b0);

        check("pending16", q16.size(), 0);
        check("pending4",  q4.size(),  0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
